// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer and the CP0 side that
// consumes its entry pulse and cause code.
package irq_sequencer_pkg;

    // Cause-code width, also used by CP0 for its cause field.
    localparam int CODE_W = 2;

    // Sequencer states; encoding is shared with CP0.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTER = 2'd2
    } irq_state_e;

endpackage : irq_sequencer_pkg

// File: rtl/irq_sequencer_prio_enc.sv
// Priority encoder: reports the highest set request index and whether any
// request is set. Index 0 is reported when nothing is set.
module irq_sequencer_prio_enc
    import irq_sequencer_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]      req_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              valid_o
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o   = CODE_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule : irq_sequencer_prio_enc

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: latches request edges, applies mask/enable and the
// in-service nesting rule, drains the pipeline and then issues a one-cycle
// entry pulse with cause code and handler vector.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int          NSRC         = 3,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
    input  logic              in_clk,
    input  logic              in_RST,
    input  logic [NSRC-1:0]   in_irq,
    input  logic              in_IE,
    input  logic [3:0]        in_INM,
    input  logic              in_eret,
    output logic              out_flush,
    output logic              out_BK,
    output logic              out_NIE,
    output logic [CODE_W-1:0] out_code,
    output logic              out_vec_valid,
    output logic [31:0]       out_vector,
    output logic [NSRC-1:0]   out_pending,
    output logic [NSRC-1:0]   out_inservice
);

    irq_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] sel_q, sel_d;
    logic [NSRC-1:0]   prev_q;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   inservice_q, inservice_d;

    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   eligible;
    logic [CODE_W-1:0] elig_idx, is_idx, enter_idx;
    logic              elig_valid, is_valid;
    logic              req, enter_fire;

    // Mask bits above NSRC carry no meaning for this instance.
    logic              unused_inm;
    assign unused_inm = ^in_INM;

    assign rise = in_irq & ~prev_q;

    // Highest in-service level sets the priority floor for nesting.
    irq_sequencer_prio_enc #(.N(NSRC)) u_is_enc (
        .req_i   (inservice_q),
        .idx_o   (is_idx),
        .valid_o (is_valid)
    );

    // Per-source eligibility and pending/in-service next-state bits.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        localparam logic [CODE_W-1:0] GI = CODE_W'(gi);
        assign eligible[gi] = pending_q[gi] & ~in_INM[gi] & (~is_valid | (GI > is_idx));
        // Entry clear first, then a fresh edge re-sets (set wins).
        assign pending_d[gi] = (pending_q[gi] & ~(enter_fire & (enter_idx == GI))) | rise[gi];
        // Eret clear uses the registered in-service view; entry sets after.
        assign inservice_d[gi] = (inservice_q[gi] & ~(in_eret & is_valid & (is_idx == GI)))
                               | (enter_fire & (enter_idx == GI));
    end

    irq_sequencer_prio_enc #(.N(NSRC)) u_elig_enc (
        .req_i   (eligible),
        .idx_o   (elig_idx),
        .valid_o (elig_valid)
    );

    assign req        = in_IE & elig_valid;
    assign enter_fire = (state_q == ST_ENTER);
    // ENTER re-selects (ignoring IE) so a higher edge during DRAIN upgrades.
    assign enter_idx  = elig_valid ? elig_idx : sel_q;

    // State, counter and source registers; async active-low clear.
    always_ff @(posedge in_clk or negedge in_RST) begin
        if (!in_RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            inservice_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            prev_q      <= in_irq;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
        end
    end

    // Next-state and entry outputs; outputs depend only on the state so
    // an asynchronous reset drops them immediately.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        out_flush     = 1'b0;
        out_BK        = 1'b0;
        out_NIE       = 1'b0;
        out_vec_valid = 1'b0;
        out_code      = '0;
        out_vector    = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES - 1);
                    sel_d   = elig_idx;
                end
            end
            ST_DRAIN: begin
                out_flush = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_ENTER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ENTER: begin
                out_flush     = 1'b1;
                out_BK        = 1'b1;
                out_NIE       = 1'b1;
                out_vec_valid = 1'b1;
                out_code      = enter_idx;
                out_vector    = VEC_BASE + VEC_STRIDE * 32'(enter_idx);
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_pending   = pending_q;
    assign out_inservice = inservice_q;

endmodule : irq_sequencer

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: expected entries are queued when
// requests are driven and compared when the entry pulse appears.
module tb_irq_sequencer;

    localparam int NSRC = 3;

    logic            in_clk = 1'b0;
    logic            in_RST = 1'b0;
    logic [NSRC-1:0] in_irq = '0;
    logic            in_IE  = 1'b1;
    logic [3:0]      in_INM = 4'b0000;
    logic            in_eret = 1'b0;
    logic            out_flush, out_BK, out_NIE, out_vec_valid;
    logic [1:0]      out_code;
    logic [31:0]     out_vector;
    logic [NSRC-1:0] out_pending, out_inservice;

    irq_sequencer dut (
        .in_clk        (in_clk),
        .in_RST        (in_RST),
        .in_irq        (in_irq),
        .in_IE         (in_IE),
        .in_INM        (in_INM),
        .in_eret       (in_eret),
        .out_flush     (out_flush),
        .out_BK        (out_BK),
        .out_NIE       (out_NIE),
        .out_code      (out_code),
        .out_vec_valid (out_vec_valid),
        .out_vector    (out_vector),
        .out_pending   (out_pending),
        .out_inservice (out_inservice)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] vector;
    } entry_t;

    entry_t exp_q[$];
    int     vec_cnt  = 0;
    int     miscmp   = 0;
    int     bk_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Entry monitor: every out_BK pulse must match the oldest queued entry.
    always @(negedge in_clk) begin
        if (out_BK) begin
            bk_seen++;
            if (exp_q.size() == 0) begin
                check_eq("bk_unexpected", 32'd1, 32'd0);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check_eq("bk_code", 32'(out_code), 32'(e.code));
                check_eq("bk_vector", out_vector, e.vector);
                check_eq("bk_nie", 32'(out_NIE), 32'd1);
                check_eq("bk_vec_valid", 32'(out_vec_valid), 32'd1);
                check_eq("bk_flush", 32'(out_flush), 32'd1);
                $display("entry: code=%0d vector=%08h", out_code, out_vector);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] code);
        entry_t e;
        e.code   = code;
        e.vector = 32'h0000_0800 + 32'h10 * 32'(code);
        exp_q.push_back(e);
    endtask

    task automatic pulse_irq(input int i);
        in_irq[i] = 1'b1;
        tick(1);
        in_irq[i] = 1'b0;
    endtask

    task automatic do_eret();
        in_eret = 1'b1;
        tick(1);
        in_eret = 1'b0;
    endtask

    task automatic wait_bk(input int budget);
        int start;
        int n;
        start = bk_seen;
        n = 0;
        while (bk_seen == start && n < budget) begin
            @(negedge in_clk);
            n++;
        end
        if (bk_seen == start) check_eq("bk_timeout", 32'd0, 32'd1);
        tick(1);
    endtask

    initial begin
        int saved;
        // Reset state
        tick(3);
        check_eq("rst_flush", 32'(out_flush), 32'd0);
        check_eq("rst_bk", 32'(out_BK), 32'd0);
        check_eq("rst_vector", out_vector, 32'd0);
        check_eq("rst_pending", 32'(out_pending), 32'd0);
        check_eq("rst_inservice", 32'(out_inservice), 32'd0);
        in_RST = 1'b1;
        tick(3);

        // Latency: edge captured at posedge P; flush P+1..P+4, BK at P+4.
        push_exp(2'd0);
        in_irq[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge in_clk);
            check_eq($sformatf("lat_flush_%0d", k), 32'(out_flush), 32'((k >= 2) && (k <= 5)));
            check_eq($sformatf("lat_bk_%0d", k), 32'(out_BK), 32'(k == 5));
            #1;
            in_irq[0] = 1'b0;
        end
        check_eq("lat_inservice", 32'(out_inservice), 32'b001);
        check_eq("lat_pending", 32'(out_pending), 32'b000);
        do_eret();
        check_eq("lat_eret", 32'(out_inservice), 32'b000);

        // Nesting
        push_exp(2'd1);
        pulse_irq(1);
        wait_bk(20);
        check_eq("nest_is1", 32'(out_inservice), 32'b010);
        push_exp(2'd2);
        pulse_irq(2);
        wait_bk(20);
        check_eq("nest_is2", 32'(out_inservice), 32'b110);
        do_eret();
        check_eq("nest_eret1", 32'(out_inservice), 32'b010);
        do_eret();
        check_eq("nest_eret2", 32'(out_inservice), 32'b000);

        // Blocked lower priority
        push_exp(2'd2);
        pulse_irq(2);
        wait_bk(20);
        check_eq("blk_is", 32'(out_inservice), 32'b100);
        pulse_irq(0);
        saved = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_flush) saved = 1;
            tick(1);
        end
        check_eq("blk_noflush", 32'(saved), 32'd0);
        check_eq("blk_pending", 32'(out_pending), 32'b001);
        push_exp(2'd0);
        do_eret();
        wait_bk(20);
        check_eq("blk_is_after", 32'(out_inservice), 32'b001);
        do_eret();

        // Masking
        in_INM = 4'b0010;
        pulse_irq(1);
        saved = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_flush) saved = 1;
            tick(1);
        end
        check_eq("mask_noflush", 32'(saved), 32'd0);
        check_eq("mask_pending", 32'(out_pending), 32'b010);
        push_exp(2'd1);
        in_INM = 4'b0000;
        wait_bk(20);
        check_eq("mask_is", 32'(out_inservice), 32'b010);
        do_eret();

        // Upgrade: irq2 arrives during DRAIN of irq0
        push_exp(2'd2);
        pulse_irq(0);
        pulse_irq(2);
        wait_bk(20);
        check_eq("upg_pending", 32'(out_pending), 32'b001);
        check_eq("upg_is", 32'(out_inservice), 32'b100);
        push_exp(2'd0);
        do_eret();
        wait_bk(20);
        check_eq("upg_is0", 32'(out_inservice), 32'b001);
        do_eret();
        check_eq("upg_empty", 32'(exp_q.size()), 32'd0);

        // Reset during DRAIN
        pulse_irq(1);
        tick(1);
        check_eq("rd_flush_pre", 32'(out_flush), 32'd1);
        saved = bk_seen;
        #2 in_RST = 1'b0;
        #1;
        check_eq("rd_flush", 32'(out_flush), 32'd0);
        check_eq("rd_bk", 32'(out_BK), 32'd0);
        check_eq("rd_pending", 32'(out_pending), 32'd0);
        check_eq("rd_inservice", 32'(out_inservice), 32'd0);
        tick(2);
        in_RST = 1'b1;
        tick(20);
        check_eq("rd_no_stale_bk", 32'(bk_seen), 32'(saved));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule : tb_irq_sequencer
